// File: rtl/mdu_pkg.sv
// Shared op codes, FSM encoding and op-class helpers for the iterative multiply/divide unit.
// MDU_MACC_EN enables the MADD/MADDU/MSUB/MSUBU accumulate forms.
package mdu_pkg;

    localparam logic [3:0] MDU_NONE  = 4'd0;
    localparam logic [3:0] MDU_MULT  = 4'd1;
    localparam logic [3:0] MDU_MULTU = 4'd2;
    localparam logic [3:0] MDU_DIV   = 4'd3;
    localparam logic [3:0] MDU_DIVU  = 4'd4;
    localparam logic [3:0] MDU_MTHI  = 4'd5;
    localparam logic [3:0] MDU_MTLO  = 4'd6;
    localparam logic [3:0] MDU_MADD  = 4'd7;
    localparam logic [3:0] MDU_MADDU = 4'd8;
    localparam logic [3:0] MDU_MSUB  = 4'd9;
    localparam logic [3:0] MDU_MSUBU = 4'd10;

    typedef enum logic [1:0] {
        StIdle,
        StBusy,
        StFix,
        StDone
    } mdu_state_e;

    function automatic logic is_div(input logic [3:0] op);
        return (op == MDU_DIV) || (op == MDU_DIVU);
    endfunction

    function automatic logic is_macc(input logic [3:0] op);
`ifdef MDU_MACC_EN
        return (op == MDU_MADD) || (op == MDU_MADDU) || (op == MDU_MSUB) || (op == MDU_MSUBU);
`else
        return (op != op);
`endif
    endfunction

    function automatic logic is_iter(input logic [3:0] op);
        return (op == MDU_MULT) || (op == MDU_MULTU) || is_div(op) || is_macc(op);
    endfunction

    // Signed forms take magnitudes on entry and fix signs up at the end.
    function automatic logic is_signed_op(input logic [3:0] op);
        return (op == MDU_MULT) || (op == MDU_DIV) || (op == MDU_MADD) || (op == MDU_MSUB);
    endfunction

endpackage

// File: rtl/mdu_div_step.sv
// One iteration of the shared datapath: restoring subtract-shift for divide, or
// shift-add for multiply, on the {acc, q} register pair.
module mdu_div_step #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             is_div_i,
    input  logic [WIDTH-1:0] acc_i,
    input  logic [WIDTH-1:0] q_i,
    input  logic [WIDTH-1:0] m_i,
    output logic [WIDTH-1:0] acc_o,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH:0] sum;
    logic [WIDTH:0] rem;
    logic [WIDTH:0] diff;

    always_comb begin
        sum  = {1'b0, acc_i} + (q_i[0] ? {1'b0, m_i} : '0);
        rem  = {acc_i, q_i[WIDTH-1]};
        diff = rem - {1'b0, m_i};
        if (is_div_i) begin
            // Top bit of diff clear means the trial subtraction did not go negative.
            if (!diff[WIDTH]) begin
                acc_o = diff[WIDTH-1:0];
                q_o   = {q_i[WIDTH-2:0], 1'b1};
            end else begin
                acc_o = rem[WIDTH-1:0];
                q_o   = {q_i[WIDTH-2:0], 1'b0};
            end
        end else begin
            acc_o = sum[WIDTH:1];
            q_o   = {sum[0], q_i[WIDTH-1:1]};
        end
    end

endmodule

// File: rtl/mdu_seq.sv
// Iterative multiply/divide unit owning HI/LO, one bit per cycle, stalling the PC while busy.
// Define MDU_MACC_EN to add the MADD/MADDU/MSUB/MSUBU accumulate operations.
module mdu_seq
    import mdu_pkg::*;
#(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned CNT_W = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             pc_ena,
    output logic             busy,
    output logic             done,
    output logic             div_zero
);

    mdu_state_e state_q, state_d;

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic [WIDTH-1:0] m_q, m_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic [3:0]       op_q, op_d;
    logic             neg_q, neg_d;
    logic             rneg_q, rneg_d;
    logic             div_zero_q, div_zero_d;

    logic             a_neg, b_neg;
    logic [WIDTH-1:0] a_abs, b_abs;
    logic [WIDTH-1:0] step_acc, step_q;
    logic [2*WIDTH-1:0] prod;

    assign a_neg = is_signed_op(op) & a[WIDTH-1];
    assign b_neg = is_signed_op(op) & b[WIDTH-1];
    assign a_abs = a_neg ? -a : a;
    assign b_abs = b_neg ? -b : b;

    mdu_div_step #(
        .WIDTH(WIDTH)
    ) u_step (
        .is_div_i(is_div(op_q)),
        .acc_i   (acc_q),
        .q_i     (q_q),
        .m_i     (m_q),
        .acc_o   (step_acc),
        .q_o     (step_q)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (is_iter(op)) begin
                    state_d = (is_div(op) && (b == '0)) ? StFix : StBusy;
                end
            end
            StBusy: begin
                if (cnt_q == CNT_W'(1)) begin
                    state_d = StFix;
                end
            end
            StFix:   state_d = StDone;
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        busy   = (state_q == StBusy) || (state_q == StFix);
        done   = (state_q == StDone);
        pc_ena = !busy && !((state_q == StIdle) && is_iter(op) && !rst);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q      <= '0;
            acc_q      <= '0;
            q_q        <= '0;
            m_q        <= '0;
            hi_q       <= '0;
            lo_q       <= '0;
            op_q       <= MDU_NONE;
            neg_q      <= 1'b0;
            rneg_q     <= 1'b0;
            div_zero_q <= 1'b0;
        end else begin
            cnt_q      <= cnt_d;
            acc_q      <= acc_d;
            q_q        <= q_d;
            m_q        <= m_d;
            hi_q       <= hi_d;
            lo_q       <= lo_d;
            op_q       <= op_d;
            neg_q      <= neg_d;
            rneg_q     <= rneg_d;
            div_zero_q <= div_zero_d;
        end
    end

    always_comb begin
        cnt_d      = cnt_q;
        acc_d      = acc_q;
        q_d        = q_q;
        m_d        = m_q;
        hi_d       = hi_q;
        lo_d       = lo_q;
        op_d       = op_q;
        neg_d      = neg_q;
        rneg_d     = rneg_q;
        div_zero_d = div_zero_q;
        prod       = neg_q ? -{acc_q, q_q} : {acc_q, q_q};
        unique case (state_q)
            StIdle: begin
                if (op == MDU_MTHI) begin
                    hi_d = a;
                end else if (op == MDU_MTLO) begin
                    lo_d = a;
                end else if (is_iter(op)) begin
                    op_d       = op;
                    cnt_d      = CNT_W'(WIDTH);
                    neg_d      = a_neg ^ b_neg;
                    rneg_d     = a_neg;
                    div_zero_d = is_div(op) && (b == '0);
                    if (is_div(op)) begin
                        // On divide-by-zero acc carries the raw dividend straight to HI.
                        acc_d = (b == '0) ? a : '0;
                        q_d   = a_abs;
                        m_d   = b_abs;
                    end else begin
                        acc_d = '0;
                        q_d   = b_abs;
                        m_d   = a_abs;
                    end
                end
            end
            StBusy: begin
                acc_d = step_acc;
                q_d   = step_q;
                cnt_d = cnt_q - CNT_W'(1);
            end
            StFix: begin
                cnt_d = '0;
                if (div_zero_q) begin
                    hi_d = acc_q;
                    lo_d = '1;
                end else if (is_div(op_q)) begin
                    lo_d = neg_q ? -q_q : q_q;
                    hi_d = rneg_q ? -acc_q : acc_q;
                end else begin
`ifdef MDU_MACC_EN
                    if ((op_q == MDU_MADD) || (op_q == MDU_MADDU)) begin
                        {hi_d, lo_d} = {hi_q, lo_q} + prod;
                    end else if ((op_q == MDU_MSUB) || (op_q == MDU_MSUBU)) begin
                        {hi_d, lo_d} = {hi_q, lo_q} - prod;
                    end else begin
                        {hi_d, lo_d} = prod;
                    end
`else
                    {hi_d, lo_d} = prod;
`endif
                end
            end
            default: ;
        endcase
    end

    assign hi       = hi_q;
    assign lo       = lo_q;
    assign div_zero = div_zero_q;

endmodule

// File: tb/tb_mdu_seq.sv
// Self-checking bench for mdu_seq: directed vector table, hand-written handshake/reset
// sequences, and randomized ops against an arithmetic reference model.
module tb_mdu_seq;
    import mdu_pkg::*;

    localparam int W = 32;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [3:0]    op_s = MDU_NONE;
    logic [W-1:0]  a_s = '0;
    logic [W-1:0]  b_s = '0;
    logic [W-1:0]  hi_s, lo_s;
    logic          pc_ena_s, busy_s, done_s, dz_s;

    int n_pass = 0;
    int n_total = 0;

    logic [W-1:0] m_hi = '0;
    logic [W-1:0] m_lo = '0;
    logic         m_dz = 1'b0;

    mdu_seq #(.WIDTH(W)) dut (
        .clk     (clk),
        .rst     (rst),
        .op      (op_s),
        .a       (a_s),
        .b       (b_s),
        .hi      (hi_s),
        .lo      (lo_s),
        .pc_ena  (pc_ena_s),
        .busy    (busy_s),
        .done    (done_s),
        .div_zero(dz_s)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]   op;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] hi;
        logic [W-1:0] lo;
        int           stall;
        logic         dz;
    } vec_t;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    function automatic logic model_iter(input logic [3:0] o);
        if (o inside {MDU_MULT, MDU_MULTU, MDU_DIV, MDU_DIVU}) return 1'b1;
`ifdef MDU_MACC_EN
        if (o inside {MDU_MADD, MDU_MADDU, MDU_MSUB, MDU_MSUBU}) return 1'b1;
`endif
        return 1'b0;
    endfunction

    // Plain-arithmetic reference: updates m_hi/m_lo/m_dz, returns expected stall length.
    task automatic model(input logic [3:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                         output int stall);
        longint sx, sy, sq, sr;
        logic [63:0] p, acc;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        stall = 0;
        if (model_iter(o)) begin
            stall = W + 2;
            m_dz = 1'b0;
        end
        if (o == MDU_MTHI) m_hi = x;
        else if (o == MDU_MTLO) m_lo = x;
        else if (o == MDU_DIV || o == MDU_DIVU) begin
            if (y == '0) begin
                m_hi = x; m_lo = '1; m_dz = 1'b1; stall = 2;
            end else if (o == MDU_DIVU) begin
                m_lo = x / y; m_hi = x % y;
            end else begin
                sq = sx / sy; sr = sx % sy;
                m_lo = sq[W-1:0]; m_hi = sr[W-1:0];
            end
        end else if (model_iter(o)) begin
            if (o == MDU_MULT || o == MDU_MADD || o == MDU_MSUB) p = 64'(sx * sy);
            else p = {32'b0, x} * {32'b0, y};
            acc = {m_hi, m_lo};
            if (o == MDU_MADD || o == MDU_MADDU) acc = acc + p;
            else if (o == MDU_MSUB || o == MDU_MSUBU) acc = acc - p;
            else acc = p;
            {m_hi, m_lo} = acc;
        end
    endtask

    task automatic run_op(input logic [3:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                          output logic [W-1:0] ghi, output logic [W-1:0] glo,
                          output int gstall, output logic gdone, output logic gdz);
        @(negedge clk);
        op_s = o; a_s = x; b_s = y;
        #1;
        gstall = 0;
        while (!pc_ena_s && gstall < 200) begin
            gstall++;
            @(negedge clk);
            #1;
        end
        gdone = done_s;
        ghi = hi_s;
        glo = lo_s;
        @(negedge clk);
        op_s = MDU_NONE;
        #1;
        if (!gdone) begin
            ghi = hi_s;
            glo = lo_s;
        end
        gdz = dz_s;
    endtask

    task automatic check_vec(input string tag, input vec_t v);
        logic [W-1:0] ghi, glo;
        int gs, ms;
        logic gd, gz;
        run_op(v.op, v.a, v.b, ghi, glo, gs, gd, gz);
        model(v.op, v.a, v.b, ms);
        chk({tag, ".hi"}, 64'(ghi), 64'(v.hi));
        chk({tag, ".lo"}, 64'(glo), 64'(v.lo));
        chk({tag, ".stall"}, 64'(gs), 64'(v.stall));
        chk({tag, ".done"}, 64'(gd), 64'(v.stall > 0));
        chk({tag, ".div_zero"}, 64'(gz), 64'(v.dz));
    endtask

    function automatic vec_t mk(input logic [3:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                                input logic [W-1:0] h, input logic [W-1:0] l, input int s,
                                input logic z);
        vec_t v;
        v.op = o; v.a = x; v.b = y; v.hi = h; v.lo = l; v.stall = s; v.dz = z;
        return v;
    endfunction

    function automatic logic [W-1:0] pick_operand();
        case ($urandom_range(0, 5))
            0: return '0;
            1: return 32'h8000_0000;
            2: return '1;
            3: return W'($urandom_range(0, 20));
            default: return W'($urandom);
        endcase
    endfunction

    initial begin
        vec_t tbl[$];
        logic [W-1:0] ghi, glo;
        int gs, ms, cyc;
        logic gd, gz;
        logic [3:0] o;
        logic [W-1:0] x, y;

        tbl.push_back(mk(MDU_MULT, 32'hFFFF_FFFD, 32'd7, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 34, 1'b0));
        tbl.push_back(mk(MDU_DIVU, 32'd100, 32'd7, 32'd2, 32'd14, 34, 1'b0));
        tbl.push_back(mk(MDU_DIV, 32'hFFFF_FF9C, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFF2, 34, 1'b0));
        tbl.push_back(mk(MDU_DIV, 32'd5, 32'd0, 32'd5, 32'hFFFF_FFFF, 2, 1'b1));
        tbl.push_back(mk(MDU_MULTU, 32'd2, 32'd3, 32'd0, 32'd6, 34, 1'b0));
        tbl.push_back(mk(MDU_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000, 34, 1'b0));
        tbl.push_back(mk(MDU_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'd1, 34, 1'b0));
        tbl.push_back(mk(MDU_DIVU, 32'd7, 32'd100, 32'd7, 32'd0, 34, 1'b0));
        tbl.push_back(mk(MDU_MTHI, 32'h0000_00AB, 32'd0, 32'h0000_00AB, 32'd0, 0, 1'b0));
        tbl.push_back(mk(4'd15, 32'd9, 32'd9, 32'h0000_00AB, 32'd0, 0, 1'b0));
`ifdef MDU_MACC_EN
        tbl.push_back(mk(MDU_MTHI, 32'd0, 32'd0, 32'd0, 32'd0, 0, 1'b0));
        tbl.push_back(mk(MDU_MTLO, 32'd10, 32'd0, 32'd0, 32'd10, 0, 1'b0));
        tbl.push_back(mk(MDU_MADD, 32'd4, 32'd5, 32'd0, 32'd30, 34, 1'b0));
        tbl.push_back(mk(MDU_MSUBU, 32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFE, 32'h0000_0020, 34, 1'b0));
`else
        tbl.push_back(mk(MDU_MADD, 32'd4, 32'd5, 32'h0000_00AB, 32'd0, 0, 1'b0));
`endif

        // Reset state
        #1;
        chk("reset.hi", 64'(hi_s), 64'd0);
        chk("reset.lo", 64'(lo_s), 64'd0);
        chk("reset.pc_ena", 64'(pc_ena_s), 64'd1);
        chk("reset.busy", 64'(busy_s), 64'd0);
        chk("reset.done", 64'(done_s), 64'd0);
        chk("reset.div_zero", 64'(dz_s), 64'd0);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < tbl.size(); i++) check_vec($sformatf("vec%0d", i), tbl[i]);

        // MTHI then MTLO back to back: no stall on either cycle
        @(negedge clk);
        op_s = MDU_MTHI; a_s = 32'h1234; #1;
        chk("mthi.pc_ena", 64'(pc_ena_s), 64'd1);
        @(negedge clk);
        op_s = MDU_MTLO; a_s = 32'h5678; #1;
        chk("mtlo.pc_ena", 64'(pc_ena_s), 64'd1);
        @(negedge clk);
        op_s = MDU_NONE; #1;
        chk("b2b.hi", 64'(hi_s), 64'h1234);
        chk("b2b.lo", 64'(lo_s), 64'h5678);
        m_hi = 32'h1234; m_lo = 32'h5678;

        // MULT held through its DONE cycle must not retrigger
        @(negedge clk);
        op_s = MDU_MULT; a_s = 32'd3; b_s = 32'd5; #1;
        cyc = 0;
        while (!done_s && cyc < 100) begin
            @(negedge clk);
            #1;
            cyc++;
        end
        chk("hold.done", 64'(done_s), 64'd1);
        chk("hold.done_at", 64'(cyc), 64'(W + 2));
        @(negedge clk);
        #1;
        chk("hold.busy_after", 64'(busy_s), 64'd0);
        chk("hold.done_once", 64'(done_s), 64'd0);
        op_s = MDU_NONE;
        @(negedge clk);
        #1;
        chk("hold.idle_busy", 64'(busy_s), 64'd0);
        chk("hold.lo", 64'(lo_s), 64'd15);
        model(MDU_MULT, 32'd3, 32'd5, ms);

        // Randomized ops against the reference model
        for (int i = 0; i < 60; i++) begin
            if ($urandom_range(0, 3) == 0) o = 4'($urandom_range(0, 15));
            else o = 4'($urandom_range(1, 4));
            x = pick_operand();
            y = pick_operand();
            run_op(o, x, y, ghi, glo, gs, gd, gz);
            model(o, x, y, ms);
            if (ghi !== m_hi || glo !== m_lo || gs != ms || gz !== m_dz || gd !== (ms > 0))
                $display("FAIL rand%0d op=%0d a=%h b=%h: got hi=%h lo=%h stall=%0d dz=%b done=%b, expected hi=%h lo=%h stall=%0d dz=%b",
                         i, o, x, y, ghi, glo, gs, gz, gd, m_hi, m_lo, ms, m_dz);
            else n_pass++;
            n_total++;
        end

        // Asynchronous reset in the middle of a DIVU
        @(negedge clk);
        op_s = MDU_DIVU; a_s = 32'd1000; b_s = 32'd3;
        repeat (10) @(negedge clk);
        #2;
        chk("pre_rst.busy", 64'(busy_s), 64'd1);
        rst = 1'b1;
        #1;
        chk("rst_mid.hi", 64'(hi_s), 64'd0);
        chk("rst_mid.lo", 64'(lo_s), 64'd0);
        chk("rst_mid.pc_ena", 64'(pc_ena_s), 64'd1);
        chk("rst_mid.busy", 64'(busy_s), 64'd0);
        chk("rst_mid.done", 64'(done_s), 64'd0);
        @(negedge clk);
        op_s = MDU_NONE;
        rst = 1'b0;
        m_hi = '0; m_lo = '0; m_dz = 1'b0;
        check_vec("after_rst", mk(MDU_DIVU, 32'd1000, 32'd3, 32'd1, 32'd333, 34, 1'b0));

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not finish, expected completion");
        $fatal(1);
    end

endmodule
